// File: rtl/signed_argmin_scanner_pkg.sv
// Shared definitions for the signed argmin scanner: FSM states, default
// sizing and the burst-length legality check.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_MAX_LEN = 16;

    function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/signed_argmin_scanner_if.sv
// Control, operand-stream and result handshake bundle for the argmin scanner.
interface signed_argmin_scanner_if
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN
);
    localparam int unsigned IDX_W = $clog2(MAX_LEN);

    logic             start;
    logic [IDX_W:0]   len;
    logic             busy;
    logic             err;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  busy, err, in_ready, out_valid, out_min, out_idx
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output busy, err, in_ready, out_valid, out_min, out_idx
    );

endinterface

// File: rtl/signed_argmin_scanner_cmp.sv
// Combinational full-width signed a <= b; drop-in point for the gate-level
// comparator netlist.
module signed_lteq_cmp #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             le
);

    assign le = $signed(a) <= $signed(b);

endmodule

// File: rtl/signed_argmin_scanner.sv
// Streams a burst of signed operands through one shared comparator and reports
// the minimum together with the index of its first occurrence.
module signed_argmin_scanner
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    signed_argmin_scanner_if.slave bus
);

    localparam int unsigned    IDX_W   = $clog2(MAX_LEN);
    localparam logic [IDX_W:0] LEN_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W:0]   r_len;
    logic [IDX_W:0]   r_cnt;
    logic [WIDTH-1:0] r_cur_min;
    logic [IDX_W-1:0] r_cur_idx;
    logic             r_err;

    logic             w_len_ok;
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_le;
    logic             w_last;

    assign w_len_ok   = len_legal(32'(bus.len), MAX_LEN);
    assign w_in_ready = (r_state == LOAD) || (r_state == SCAN);
    assign w_xfer     = w_in_ready && bus.in_valid;
    assign w_last     = (r_cnt == (r_len - LEN_ONE));

    signed_lteq_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (r_cur_min),
        .b  (bus.in_data),
        .le (w_le)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start && w_len_ok) w_next = LOAD;
            LOAD:    if (w_xfer) w_next = (r_len == LEN_ONE) ? DONE : SCAN;
            SCAN:    if (w_xfer && w_last) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_cur_min <= '0;
            r_cur_idx <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && bus.start && !w_len_ok;
            unique case (r_state)
                IDLE: begin
                    if (bus.start && w_len_ok) begin
                        r_len <= bus.len;
                        r_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        r_cur_min <= bus.in_data;
                        r_cur_idx <= '0;
                        r_cnt     <= LEN_ONE;
                    end
                end
                SCAN: begin
                    // Replace only on strictly smaller so ties keep the earlier index.
                    if (w_xfer) begin
                        if (!w_le) begin
                            r_cur_min <= bus.in_data;
                            r_cur_idx <= r_cnt[IDX_W-1:0];
                        end
                        r_cnt <= r_cnt + LEN_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_min   = r_cur_min;
    assign bus.out_idx   = r_cur_idx;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_signed_argmin_scanner.sv
// Self-checking bench: burst-level reference model compared every cycle, plus
// directed bursts with hand-computed results.
module tb_signed_argmin_scanner;

    localparam int unsigned W  = 32;
    localparam int unsigned ML = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    signed_argmin_scanner_if #(.WIDTH(W), .MAX_LEN(ML)) bus ();

    signed_argmin_scanner #(
        .WIDTH   (W),
        .MAX_LEN (ML)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- reference model (burst level) ----------------
    typedef enum {M_IDLE, M_COLLECT, M_REPORT} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int unsigned m_len  = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_min  = '0;
    int unsigned m_idx  = 0;
    logic        m_err  = 1'b0;

    function automatic logic [31:0] q_min();
        logic [31:0] best;
        best = m_q[0];
        foreach (m_q[i]) if ($signed(m_q[i]) < $signed(best)) best = m_q[i];
        return best;
    endfunction

    function automatic int unsigned q_idx();
        logic [31:0] best;
        best = q_min();
        for (int i = 0; i < m_q.size(); i++) if (m_q[i] == best) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_err  <= 1'b0;
            m_q.delete();
        end else begin
            m_err <= 1'b0;
            case (m_mode)
                M_IDLE: if (bus.start) begin
                    if (bus.len == 0 || bus.len > ML) m_err <= 1'b1;
                    else begin
                        m_len  <= bus.len;
                        m_q.delete();
                        m_mode <= M_COLLECT;
                    end
                end
                M_COLLECT: if (bus.in_valid) begin
                    m_q.push_back(bus.in_data);
                    if (m_q.size() == m_len) begin
                        m_min  <= q_min();
                        m_idx  <= q_idx();
                        m_mode <= M_REPORT;
                    end
                end
                M_REPORT: if (bus.out_ready) m_mode <= M_IDLE;
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", bus.busy, m_mode != M_IDLE);
        chk("in_ready", bus.in_ready, m_mode == M_COLLECT);
        chk("out_valid", bus.out_valid, m_mode == M_REPORT);
        chk("err", bus.err, m_err);
        if (m_mode == M_REPORT) begin
            chk("out_min", bus.out_min, m_min);
            chk("out_idx", bus.out_idx, m_idx);
        end
    end

    // ---------------- drivers ----------------
    logic [31:0] tx_q[$];

    task automatic do_start(input int l);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 5'(l);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle after each operand, 2 random idles
    task automatic send_ops(input int gap_mode);
        int n;
        while (tx_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tx_q[0];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.in_ready && n < 200);
            if (!bus.in_ready) begin
                fail_now("in_ready_wait");
                bus.in_valid = 1'b0;
                tx_q.delete();
                return;
            end
            @(posedge clk); #1;
            void'(tx_q.pop_front());
            bus.in_valid = 1'b0;
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 200);
        ok = bus.out_valid;
        if (!ok) fail_now("out_valid_wait");
    endtask

    task automatic wait_result(input logic [31:0] emin, input int eidx, input string name);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            chk({name, "_min"}, bus.out_min, emin);
            chk({name, "_idx"}, bus.out_idx, eidx);
        end
    endtask

    task automatic release_result();
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic err_case(input int l, input string name);
        do_start(l);
        @(negedge clk);
        chk({name, "_err_hi"}, bus.err, 1'b1);
        chk({name, "_busy"}, bus.busy, 1'b0);
        @(negedge clk);
        chk({name, "_err_lo"}, bus.err, 1'b0);
        chk({name, "_busy2"}, bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int l;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_min", bus.out_min, 32'h0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back burst; result the cycle after the last transfer.
        do_start(4);
        tx_q = '{32'd5, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFD};
        send_ops(0);
        @(negedge clk);
        chk("t1_latency", bus.out_valid, 1'b1);
        wait_result(32'hFFFFFFFD, 1, "t1");
        release_result();

        do_start(2);
        tx_q = '{32'h7FFFFFFF, 32'h80000000};
        send_ops(0);
        wait_result(32'h80000000, 1, "t2a");
        release_result();

        do_start(2);
        tx_q = '{32'h80000000, 32'h80000000};
        send_ops(0);
        wait_result(32'h80000000, 0, "t2b");
        release_result();

        do_start(1);
        tx_q = '{32'h0};
        send_ops(0);
        @(negedge clk);
        chk("t3_latency", bus.out_valid, 1'b1);
        wait_result(32'h0, 0, "t3");
        release_result();

        err_case(0, "len0");
        err_case(17, "len17");

        do_start(16);
        for (int i = 15; i >= 0; i--) tx_q.push_back(32'(i));
        send_ops(1);
        wait_result(32'h0, 15, "t4");
        release_result();

        // Result held while out_ready stays low; start pulses ignored.
        do_start(3);
        tx_q = '{32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF};
        send_ops(0);
        wait_result(32'hFFFFFFFF, 1, "t5");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.start = (i % 2 == 0);
            bus.len   = 5'd3;
            @(negedge clk);
            chk("t5_hold_min", bus.out_min, 32'hFFFFFFFF);
            chk("t5_hold_idx", bus.out_idx, 1);
            chk("t5_hold_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_idle_busy", bus.busy, 1'b0);
        chk("t5_idle_valid", bus.out_valid, 1'b0);

        // Asynchronous abort mid-scan.
        do_start(4);
        tx_q = '{32'd1, 32'd2};
        send_ops(0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_valid", bus.out_valid, 1'b0);
        chk("t6_rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(3);
        tx_q = '{32'd9, 32'd8, 32'd9};
        send_ops(0);
        wait_result(32'd8, 1, "t6");
        release_result();

        // Randomized bursts checked by the reference model.
        for (int b = 0; b < 40; b++) begin
            l = $urandom_range(0, 17);
            if (l == 0 || l > 16) begin
                do_start(l);
                repeat (2) @(posedge clk);
                continue;
            end
            do_start(l);
            for (int i = 0; i < l; i++) begin
                case ($urandom_range(0, 2))
                    0: tx_q.push_back($urandom);
                    1: tx_q.push_back(32'($signed($urandom_range(0, 3)) - 2));
                    default: case ($urandom_range(0, 3))
                        0: tx_q.push_back(32'h80000000);
                        1: tx_q.push_back(32'h7FFFFFFF);
                        2: tx_q.push_back(32'h0);
                        default: tx_q.push_back(32'hFFFFFFFF);
                    endcase
                endcase
            end
            send_ops(2);
            wait_valid(ok);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            release_result();
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/signed_argmin_scanner.md
Name: signed_argmin_scanner

Overview:
- Sequential controller that time-shares one combinational signed less-than-or-equal comparator across a burst of streamed operands.
- Returns the minimum value of the burst and the index of its first occurrence.
- Sits in the crypto benchmark comparator family as the sequenced, handshaked consumer of the 32-bit signed comparator.
- Accepts one operand per cycle and reports once per burst.

Parameters:
WIDTH, 32, operand width in bits; two's-complement signed.
MAX_LEN, 16, maximum burst length; must be at least 2.
IDX_W, $clog2(MAX_LEN), index width; derived, not overridden.

Ports:
clk  input  1  clock; rising edge.
rst_n  input  1  reset; asynchronous, active-low.
start  input  1  begins a burst; sampled only in IDLE.
len  input  IDX_W+1  burst length; sampled with start; legal range 1..MAX_LEN.
busy  output  1  high in LOAD, SCAN and DONE.
err  output  1  one-cycle pulse when start arrives with an illegal len.
in_valid  input  1  operand valid.
in_ready  output  1  operand ready.
in_data  input  WIDTH  signed operand.
out_valid  output  1  result valid.
out_ready  input  1  result accepted.
out_min  output  WIDTH  minimum operand of the burst.
out_idx  output  IDX_W  index of the first occurrence of the minimum.

Behaviour:
- Reset values: all state registers cleared; state=IDLE; busy, err, in_ready, out_valid = 0; out_min, out_idx = 0.
- Reset mid-operation: asserting rst_n low at any point aborts the burst immediately. No result is emitted for the aborted burst.
- Transfers occur only on a cycle where both valid and ready are high at the rising edge.
- State IDLE:
  - start with len in 1..MAX_LEN: latch len, clear the counter, go to LOAD.
  - start with len == 0 or len > MAX_LEN: err=1 for one cycle, remain in IDLE.
- State LOAD:
  - in_ready=1.
  - On transfer: cur_min <= in_data, cur_idx <= 0, cnt <= 1.
  - If len == 1, go to DONE; otherwise go to SCAN.
- State SCAN:
  - in_ready=1.
  - On each transfer, evaluate le = signed(cur_min) <= signed(in_data) using the sub-module.
  - If !le (strictly smaller), cur_min <= in_data and cur_idx <= cnt. Ties keep the earlier index.
  - cnt increments on every transfer. When the transfer at cnt == len-1 completes, go to DONE.
  - Gaps in in_valid stall the scan without penalty.
- State DONE:
  - in_ready=0; out_valid=1; out_min and out_idx hold registered values and stay stable while out_valid && !out_ready.
  - On out_ready, go to IDLE and drop out_valid next cycle.
- Latency: out_valid rises on the first cycle after the last operand transfer. Throughput is one operand per cycle.
- start is ignored whenever state != IDLE; no err is raised for it.
- Arithmetic: the comparison is full-width signed, with no overflow path. 0x80000000 is the most negative value and 0x7FFFFFFF the most positive.
- cnt is IDX_W+1 bits wide so that it does not wrap at len == MAX_LEN.
- in_ready is a registered state decode with no combinational path from in_valid. out_valid likewise has no combinational path from out_ready.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum {IDLE, LOAD, SCAN, DONE};
  - the default WIDTH and MAX_LEN constants;
  - a len-legality function.
- Sub-module signed_lteq_cmp (parameter WIDTH; inputs a, b; output le = a <= b, signed):
  - purely combinational;
  - swappable for the optimized gate-level comparator netlist.
  - It is instantiated once and shared by every SCAN cycle.

Test Plan:
- len=4; data 5, -3, 7, -3 back-to-back -> out_min=-3 (0xFFFFFFFD), out_idx=1; out_valid on the cycle after the 4th transfer.
- len=2; data 0x7FFFFFFF, 0x80000000 -> out_min=0x80000000, out_idx=1. Then len=2; data 0x80000000, 0x80000000 -> out_idx=0 (tie keeps first).
- len=1; data 0 -> out_min=0, out_idx=0; DONE reached without entering SCAN. Then len=0 and len=17 -> one-cycle err each, busy stays 0.
- len=16; descending data 15..0 with in_valid low every other cycle -> out_min=0, out_idx=15; cnt does not wrap.
- Hold out_ready=0 for 5 cycles in DONE while pulsing start -> out_min/out_idx stable, in_ready=0, no new burst; out_ready=1 returns to IDLE.
- Drop rst_n mid-SCAN after 2 of 4 operands -> busy, out_valid, in_ready = 0 immediately. A fresh len=3 burst of 9, 8, 9 -> out_min=8, out_idx=1.
